// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types for the APB request arbiter
//
// Package apb_arb_pkg
//   state_t      : transfer FSM states (IDLE, SETUP, ACCESS)
//   DEF_AWIDTH   : default APB address width
//   DEF_DWIDTH   : default APB data width
//   addr_t/data_t: APB address/data words at the default widths
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int DEF_AWIDTH = 8;
    localparam int DEF_DWIDTH = 32;

    typedef logic [DEF_AWIDTH-1:0] addr_t;
    typedef logic [DEF_DWIDTH-1:0] data_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner select
//
// Picks the first asserted request searching upward from last+1 with wrap.
// Ports:
//   req    in  NREQ  request vector
//   last   in  IW    index of the most recently served requester
//   winner out NREQ  one-hot winner (all zero when no request)
//   index  out IW    binary index of the winner
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int  NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] winner,
    output logic [IW-1:0]   index
);

    logic found;
    int   pos;

    always_comb begin
        winner = '0;
        index  = '0;
        found  = 1'b0;
        pos    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = (int'(last) + k) % NREQ;
            if (!found && req[pos]) begin
                found       = 1'b1;
                winner[pos] = 1'b1;
                index       = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin multi-requester APB master
//
// Shares one APB slave among NREQ requesters. Optional ACCESS-phase timeout
// is enabled by defining APB_ARB_TIMEOUT_EN.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req/req_write         per-requester request level and direction
//   req_addr/req_wdata    packed per-requester payload
//   gnt                   one-hot payload-captured acknowledge (SETUP cycle)
//   done                  one-hot completion pulse
//   rsp_rdata/rsp_err     response data and abort flag, valid with done
//   p_sel/p_en/p_write    APB control
//   addr/wdata/rdata      APB address and data
//   p_ready               APB ready
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AWIDTH  = DEF_AWIDTH,
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*AWIDTH-1:0] req_addr,
    input  logic [NREQ*DWIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [DWIDTH-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   p_sel,
    output logic                   p_en,
    output logic                   p_write,
    output logic [AWIDTH-1:0]      addr,
    output logic [DWIDTH-1:0]      wdata,
    input  logic [DWIDTH-1:0]      rdata,
    input  logic                   p_ready
);

    localparam int IW = $clog2(NREQ);

    state_t            state;
    logic [IW-1:0]     last_ptr;
    logic [IW-1:0]     cur_idx;
    logic [NREQ-1:0]   cur_gnt;
    logic [IW-1:0]     arb_last;
    logic [IW-1:0]     win_idx;
    logic [NREQ-1:0]   win;
    logic              any_req;
    logic              xfer_ok;
    logic              xfer_end;
    logic              launch;
    logic [AWIDTH-1:0] sel_addr;
    logic [DWIDTH-1:0] sel_wdata;
    logic              sel_write;

    assign any_req = |req;

    // A transfer that ends this cycle becomes "last" at the same edge, so the
    // back-to-back arbitration must already see the current owner as last.
    assign arb_last = (state == ACCESS) ? cur_idx : last_ptr;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req    (req),
        .last   (arb_last),
        .winner (win),
        .index  (win_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                sel_addr  = req_addr[i*AWIDTH +: AWIDTH];
                sel_wdata = req_wdata[i*DWIDTH +: DWIDTH];
                sel_write = req_write[i];
            end
        end
    end

    assign xfer_ok = (state == ACCESS) && p_ready;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;
    logic          xfer_to;
    logic          err_q;

    // Abort on the TIMEOUT-th consecutive not-ready ACCESS cycle.
    assign xfer_to  = (state == ACCESS) && !p_ready && (wait_cnt == TW'(TIMEOUT - 1));
    assign xfer_end = xfer_ok || xfer_to;
    assign rsp_err  = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == SETUP) begin
                wait_cnt <= '0;
            end else if (state == ACCESS && !p_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (xfer_end) begin
                err_q <= xfer_to;
            end
        end
    end
`else
    assign xfer_end = xfer_ok;
    assign rsp_err  = 1'b0;
`endif

    assign launch = any_req && ((state == IDLE) || xfer_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            p_sel     <= 1'b0;
            p_en      <= 1'b0;
            p_write   <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            gnt       <= '0;
            done      <= '0;
            rsp_rdata <= '0;
            last_ptr  <= IW'(NREQ - 1);
            cur_idx   <= '0;
            cur_gnt   <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;

            if (xfer_end) begin
                done      <= cur_gnt;
                last_ptr  <= cur_idx;
                rsp_rdata <= (xfer_ok && !p_write) ? rdata : '0;
            end

            if (launch) begin
                state   <= SETUP;
                p_sel   <= 1'b1;
                p_en    <= 1'b0;
                p_write <= sel_write;
                addr    <= sel_addr;
                wdata   <= sel_wdata;
                gnt     <= win;
                cur_gnt <= win;
                cur_idx <= win_idx;
            end else begin
                case (state)
                    SETUP: begin
                        state <= ACCESS;
                        p_en  <= 1'b1;
                    end
                    ACCESS: begin
                        if (xfer_end) begin
                            state <= IDLE;
                            p_sel <= 1'b0;
                            p_en  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - scoreboard bench for apb_req_arbiter
module tb_apb_req_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 32;

    logic             clk;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  done;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic             p_sel;
    logic             p_en;
    logic             p_write;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wdata;
    logic [DW-1:0]    rdata;
    logic             p_ready;

    apb_req_arbiter #(
        .NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .p_sel(p_sel), .p_en(p_en),
        .p_write(p_write), .addr(addr), .wdata(wdata), .rdata(rdata),
        .p_ready(p_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // APB slave model: wait_cfg not-ready cycles per ACCESS, then ready.
    logic [DW-1:0] mem [0:255];
    int wait_cfg;
    int acc_cnt;
    int wr_count;

    assign p_ready = p_sel && p_en && (acc_cnt >= wait_cfg);
    assign rdata   = mem[addr];

    always @(posedge clk) begin
        if (rst) acc_cnt <= 0;
        else if (p_sel && p_en && !p_ready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (!rst && p_sel && p_en && p_ready && p_write) begin
            mem[addr] <= wdata;
            wr_count  <= wr_count + 1;
        end
    end

    typedef struct {
        int          idx;
        logic [31:0] rd;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_ready;

    function automatic void push_exp(input int i, input logic [31:0] rd, input bit err);
        exp_t e;
        e.idx = i;
        e.rd  = rd;
        e.err = err;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_ready <= 1'b0;
        end else begin
            check("pen_without_psel", 64'(p_en & ~p_sel), 0);
            if (done != 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_onehot", 64'(done), 64'(1 << mon_e.idx));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rd));
                    check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
                    if (!mon_e.err) check("done_after_ready", 64'(prev_ready), 1);
                end
            end
            prev_ready <= p_sel & p_en & p_ready;
        end
    end

    task automatic wait_gnt(input int i);
        for (int c = 0; c < 100; c++) begin
            if (gnt[i]) break;
            @(negedge clk);
        end
        check($sformatf("gnt_seen_%0d", i), 64'(gnt[i]), 1);
    endtask

    task automatic issue(input int i, input bit wr, input logic [7:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd, input bit exp_err);
        req_write[i]         = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req[i]               = 1'b1;
        push_exp(i, exp_rd, exp_err);
        @(negedge clk);
        wait_gnt(i);
        req[i] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 300; c++) begin
            if (exp_q.size() == 0 && !p_sel) break;
            @(negedge clk);
        end
        check("drain", 64'(exp_q.size()), 0);
    endtask

    task automatic count_access(input logic [7:0] a, output int n);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done != 0) break;
            if (p_en) begin
                n++;
                check("access_psel", 64'(p_sel), 1);
                check("access_addr", 64'(addr), 64'(a));
            end
        end
    endtask

    int          n;
    int          w0;
    int          stamp [5];
    logic [3:0]  gseen [5];
    logic [3:0]  gexp  [5];

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    initial begin
        gexp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        wait_cfg = 0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_psel", 64'(p_sel), 0);
        check("rst_pen", 64'(p_en), 0);
        check("rst_pwrite", 64'(p_write), 0);
        check("rst_addr", 64'(addr), 0);
        check("rst_wdata", 64'(wdata), 0);
        check("rst_gnt", 64'(gnt), 0);
        check("rst_done", 64'(done), 0);
        check("rst_rdata", 64'(rsp_rdata), 0);
        check("rst_err", 64'(rsp_err), 0);
        rst = 1'b0;
        @(negedge clk);

        // single write with cycle-exact latency
        req_write[2] = 1'b1;
        req_addr[2*AW +: AW] = 8'h10;
        req_wdata[2*DW +: DW] = 32'hDEADBEEF;
        req[2] = 1'b1;
        push_exp(2, 32'h0, 1'b0);
        @(negedge clk);
        check("setup_gnt", 64'(gnt), 4);
        check("setup_psel", 64'(p_sel), 1);
        check("setup_pen", 64'(p_en), 0);
        req[2] = 1'b0;
        @(negedge clk);
        check("access_pen", 64'(p_en), 1);
        check("access_gnt", 64'(gnt), 0);
        check("wr_addr", 64'(addr), 64'h10);
        check("wr_pwrite", 64'(p_write), 1);
        check("wr_wdata", 64'(wdata), 64'hDEADBEEF);
        @(negedge clk);
        check("wr_done", 64'(done), 4);
        check("wr_idle_psel", 64'(p_sel), 0);
        check("mem_10", 64'(mem[8'h10]), 64'hDEADBEEF);

        // read-back and response hold
        issue(1, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        wait_drain();
        check("rd_value", 64'(rsp_rdata), 64'hDEADBEEF);
        repeat (3) @(negedge clk);
        check("rd_hold", 64'(rsp_rdata), 64'hDEADBEEF);

        // contention from reset: 0,1,2,3,0 back-to-back
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_write[i] = 1'b1;
            req_addr[i*AW +: AW] = 8'(8'h20 + i);
            req_wdata[i*DW +: DW] = 32'hA000_0000 + i;
        end
        req = 4'hF;
        push_exp(0, 0, 0); push_exp(1, 0, 0); push_exp(2, 0, 0);
        push_exp(3, 0, 0); push_exp(0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            @(negedge clk);
            if (gnt != 0) begin
                gseen[n] = gnt;
                stamp[n] = c;
                n++;
            end
        end
        req = '0;
        check("cont_grants", 64'(n), 5);
        for (int k = 0; k < 5; k++) check($sformatf("cont_order_%0d", k), 64'(gseen[k]), 64'(gexp[k]));
        for (int k = 1; k < 5; k++) check($sformatf("cont_gap_%0d", k), 64'(stamp[k] - stamp[k-1]), 2);
        wait_drain();
        for (int i = 0; i < NREQ; i++) check($sformatf("cont_mem_%0d", i), 64'(mem[8'h20 + i]), 64'(32'hA000_0000 + i));

        // wait states: three not-ready ACCESS cycles
        wait_cfg = 3;
        issue(3, 1'b0, 8'h22, 32'h0, 32'hA000_0002, 1'b0);
        count_access(8'h22, n);
        check("wait_access_cycles", 64'(n), 4);
        wait_drain();
        wait_cfg = 0;

        // reset in ACCESS: no done, pointer back to requester 0
        issue(1, 1'b0, 8'h21, 32'h0, 32'hA000_0001, 1'b0);
        wait_drain();
        wait_cfg = 5;
        w0 = wr_count;
        issue(2, 1'b1, 8'h30, 32'h1234_5678, 32'h0, 1'b0);
        @(negedge clk);
        check("midrst_in_access", 64'(p_en), 1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_psel", 64'(p_sel), 0);
        check("midrst_pen", 64'(p_en), 0);
        check("midrst_done", 64'(done), 0);
        rst = 1'b0;
        wait_cfg = 0;
        req_write[0] = 1'b0; req_addr[0*AW +: AW] = 8'h20;
        req_write[3] = 1'b0; req_addr[3*AW +: AW] = 8'h23;
        push_exp(0, 32'hA000_0000, 1'b0);
        push_exp(3, 32'hA000_0003, 1'b0);
        req[0] = 1'b1;
        req[3] = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 50; c++) begin
            if (gnt != 0) break;
            @(negedge clk);
        end
        check("midrst_first_gnt", 64'(gnt), 1);
        req[0] = 1'b0;
        wait_gnt(3);
        req[3] = 1'b0;
        wait_drain();
        check("midrst_no_write", 64'(wr_count - w0), 0);

`ifdef APB_ARB_TIMEOUT_EN
        // stuck slave: abort after 16 ACCESS cycles, then serve the next request
        wait_cfg = 1000;
        issue(1, 1'b0, 8'h10, 32'h0, 32'h0, 1'b1);
        req_write[2] = 1'b1;
        req_addr[2*AW +: AW] = 8'h31;
        req_wdata[2*DW +: DW] = 32'h5555_AAAA;
        push_exp(2, 32'h0, 1'b1);
        req[2] = 1'b1;
        count_access(8'h10, n);
        check("timeout_access_cycles", 64'(n), 16);
        wait_gnt(2);
        req[2] = 1'b0;
        wait_drain();
        wait_cfg = 0;
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
